// File: rtl/ahb_bram_slave.sv
// AHB-Lite responder in front of a simple-dual-port block RAM.
// Port A (byte-writable) takes writes in the AHB data phase. Port B is a
// registered read port: it is addressed during the address phase, so its data
// lines up with the data phase and reads complete with zero wait states.
// A read issued while a write is still in its data phase sees stale RAM data.
// The write bytes are therefore captured and merged into that read's result.
// Illegal sizes or alignments get the two-cycle AHB ERROR response.
module ahb_bram_slave #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    input  logic [31:0]           HWDATA,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [3:0]            ram_wea,
    output logic [31:0]           ram_dina,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [31:0]           ram_doutb
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } state_t;

    state_t                state;

    // Address-phase decode
    logic                  accept;
    logic                  illegal;
    logic [3:0]            req_mask;
    logic [ADDR_WIDTH-1:0] req_addr;

    // Data-phase bookkeeping
    logic                  wr_pend;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [3:0]            wr_mask;
    logic                  rd_pend;
    logic [ADDR_WIDTH-1:0] rd_addr;

    // Read-after-write forwarding
    logic                  fwd_valid;
    logic [ADDR_WIDTH-1:0] fwd_addr;
    logic [3:0]            fwd_mask;
    logic [31:0]           fwd_data;

    // Address bits above the RAM and the SEQ/NONSEQ distinction are irrelevant here
    logic                  unused_bits;
    assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

    assign accept   = HSEL & HTRANS[1] & HREADY & (state == IDLE);
    assign req_addr = HADDR[ADDR_WIDTH+1:2];

    // Little-endian byte-lane mask and size/alignment legality of the request
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        req_mask = 4'b0000;
        illegal  = 1'b0;
        case (HSIZE)
            3'd0: req_mask = 4'b0001 << HADDR[1:0];
            3'd1: begin
                req_mask = HADDR[1] ? 4'b1100 : 4'b0011;
                illegal  = HADDR[0];
            end
            3'd2: begin
                req_mask = 4'b1111;
                illegal  = (HADDR[1:0] != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
    end

    // Response FSM: HREADYOUT/HRESP are registered alongside the state
    always_ff @(posedge HCLK) begin
        // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
        if (!HRESETn) begin
            state     <= IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && illegal) begin
                        state     <= ERR1;
                        HREADYOUT <= 1'b0;
                        HRESP     <= 1'b1;
                    end
                end
                ERR1: begin
                    state     <= ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                end
                ERR2: begin
                    state     <= IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                end
            endcase
        end
    end

    // Control flags for the coming data phase and the one-cycle forward window
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            wr_pend   <= 1'b0;
            rd_pend   <= 1'b0;
            fwd_valid <= 1'b0;
        end else begin
            wr_pend   <= accept & ~illegal & HWRITE;
            rd_pend   <= accept & ~illegal & ~HWRITE;
            fwd_valid <= accept & ~illegal & ~HWRITE & wr_pend;
        end
    end

    // Address/mask/data captures; qualified by the flags above
    always_ff @(posedge HCLK) begin
        // NOTE: datapath registers carry no reset; the reset-cleared flags above gate every use of them.
        if (accept) begin
            wr_addr <= req_addr;
            wr_mask <= req_mask;
            rd_addr <= req_addr;
        end
        if (wr_pend) begin
            fwd_addr <= wr_addr;
            fwd_mask <= wr_mask;
            fwd_data <= HWDATA;
        end
    end

    // RAM port A: write in the data phase, suppressed while reset is asserted
    always_comb begin
        ram_addra = wr_addr;
        ram_dina  = HWDATA;
        ram_wea   = (wr_pend && HRESETn) ? wr_mask : 4'b0000;
    end

    // RAM port B is addressed straight from the bus so data arrives in the data phase
    assign ram_addrb = req_addr;

    // Read data: RAM word with freshly written bytes merged in, zero outside reads
    always_comb begin
        HRDATA = 32'h0;
        if (rd_pend) begin
            HRDATA = ram_doutb;
            if (fwd_valid && (fwd_addr == rd_addr)) begin
                for (int i = 0; i < 4; i++) begin
                    if (fwd_mask[i]) begin
                        HRDATA[8*i +: 8] = fwd_data[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_bram_slave.sv
// Scoreboard bench for ahb_bram_slave with a behavioural block RAM attached.
// The driver pushes the expected data-phase result of every transfer it issues.
// A negedge monitor pops and compares entries as the data phases happen.
module tb_ahb_bram_slave;

    localparam int AW = 12;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic          HREADY;
    logic [31:0]   HWDATA;
    logic [31:0]   HRDATA;
    logic          HREADYOUT;
    logic          HRESP;
    logic [AW-1:0] ram_addra;
    logic [3:0]    ram_wea;
    logic [31:0]   ram_dina;
    logic [AW-1:0] ram_addrb;
    logic [31:0]   ram_doutb;

    // Single slave on the bus: bus-level ready is this slave's ready
    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahb_bram_slave #(.ADDR_WIDTH(AW)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWRITE    (HWRITE),
        .HREADY    (HREADY),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .ram_addra (ram_addra),
        .ram_wea   (ram_wea),
        .ram_dina  (ram_dina),
        .ram_addrb (ram_addrb),
        .ram_doutb (ram_doutb)
    );

    // Behavioural simple-dual-port RAM: byte-write port A, registered read port B
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge HCLK) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_wea[i]) mem[ram_addra][8*i +: 8] <= ram_dina[8*i +: 8];
        end
        ram_doutb <= mem[ram_addrb];
    end

    typedef struct {
        string       tag;
        bit          is_err;
        bit          is_read;
        logic [31:0] data;
        logic [3:0]  wea;
        logic [AW-1:0] waddr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [31:0] ref_mem [int];
    logic [31:0] nxt_wdata;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic        acc_q  = 1'b0;
    int          err_stage = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit tb_legal(input logic [2:0] s, input logic [1:0] a);
        return (s == 3'd0) || (s == 3'd1 && !a[0]) || (s == 3'd2 && a == 2'b00);
    endfunction

    function automatic logic [3:0] tb_mask(input logic [2:0] s, input logic [1:0] a);
        case (s)
            3'd0:    return 4'b0001 << a;
            3'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // One bus cycle: data phase of the previous transfer plus a new address phase
    task automatic drive(input bit act, input bit wr, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata,
                         input string tag, input bit rstn, input bit drop);
        exp_t        it;
        logic [31:0] bm;
        int          w;
        @(posedge HCLK);
        #1;
        mon_en    = 1'b1;
        HRESETn   = rstn;
        HWDATA    = nxt_wdata;
        nxt_wdata = 32'h0;
        HSEL      = act;
        HTRANS    = act ? 2'b10 : 2'b00;
        HADDR     = addr;
        HSIZE     = size;
        HWRITE    = wr;
        if (act) begin
            w          = int'(addr[AW+1:2]);
            it.tag     = tag;
            it.is_err  = !tb_legal(size, addr[1:0]);
            it.is_read = !wr;
            it.data    = 32'h0;
            it.wea     = 4'b0000;
            it.waddr   = addr[AW+1:2];
            if (!it.is_err && !wr) it.data = ref_mem[w];
            if (!it.is_err && wr) begin
                nxt_wdata = wdata;
                it.data   = wdata;
                if (!drop) begin
                    it.wea = tb_mask(size, addr[1:0]);
                    bm = {{8{it.wea[3]}}, {8{it.wea[2]}}, {8{it.wea[1]}}, {8{it.wea[0]}}};
                    if (ref_mem.exists(w)) ref_mem[w] = (ref_mem[w] & ~bm) | (wdata & bm);
                    else                   ref_mem[w] = wdata & bm;
                end
            end
            exp_q.push_back(it);
        end
    endtask

    task automatic wr_t(input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] data, input string tag, input bit drop = 1'b0);
        drive(1'b1, 1'b1, addr, size, data, tag, 1'b1, drop);
    endtask

    task automatic rd_t(input logic [31:0] addr, input string tag, input logic [2:0] size = 3'd2);
        drive(1'b1, 1'b0, addr, size, 32'h0, tag, 1'b1, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 3'd2, 32'h0, "idle", 1'b1, 1'b0);
    endtask

    task automatic rst_cycle();
        drive(1'b0, 1'b0, 32'h0, 3'd2, 32'h0, "rst", 1'b0, 1'b0);
    endtask

    // Which edges accepted a transfer, as seen by the master
    always @(posedge HCLK) acc_q <= HRESETn & HSEL & HTRANS[1] & HREADY;

    // Data-phase monitor: compares DUT outputs against queued expectations
    always @(negedge HCLK) begin
        if (mon_en) begin
            if (err_stage != 0) begin
                check({cur.tag, "_err2_ready"}, {31'b0, HREADYOUT}, 32'd1);
                check({cur.tag, "_err2_resp"},  {31'b0, HRESP},     32'd1);
                check({cur.tag, "_err2_wea"},   {28'b0, ram_wea},   32'd0);
                err_stage = 0;
            end else if (acc_q) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", {31'b0, acc_q}, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    if (cur.is_err) begin
                        check({cur.tag, "_err1_ready"}, {31'b0, HREADYOUT}, 32'd0);
                        check({cur.tag, "_err1_resp"},  {31'b0, HRESP},     32'd1);
                        check({cur.tag, "_err1_wea"},   {28'b0, ram_wea},   32'd0);
                        err_stage = 1;
                    end else begin
                        check({cur.tag, "_ready"}, {31'b0, HREADYOUT}, 32'd1);
                        check({cur.tag, "_resp"},  {31'b0, HRESP},     32'd0);
                        if (cur.is_read) begin
                            check({cur.tag, "_hrdata"}, HRDATA, cur.data);
                            check({cur.tag, "_rd_wea"}, {28'b0, ram_wea}, 32'd0);
                        end else begin
                            check({cur.tag, "_wea"}, {28'b0, ram_wea}, {28'b0, cur.wea});
                            if (cur.wea != 4'b0000) begin
                                check({cur.tag, "_addra"}, {20'b0, ram_addra}, {20'b0, cur.waddr});
                                check({cur.tag, "_dina"},  ram_dina, cur.data);
                            end
                        end
                    end
                end
            end else begin
                check("idle_ready",  {31'b0, HREADYOUT}, 32'd1);
                check("idle_resp",   {31'b0, HRESP},     32'd0);
                check("idle_wea",    {28'b0, ram_wea},   32'd0);
                check("idle_hrdata", HRDATA,             32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn   = 1'b0;
        HSEL      = 1'b0;
        HADDR     = 32'h0;
        HTRANS    = 2'b00;
        HSIZE     = 3'd2;
        HWRITE    = 1'b0;
        HWDATA    = 32'h0;
        nxt_wdata = 32'h0;
        repeat (3) @(posedge HCLK);
        #1;
        check("rst_ready",  {31'b0, HREADYOUT}, 32'd1);
        check("rst_resp",   {31'b0, HRESP},     32'd0);
        check("rst_wea",    {28'b0, ram_wea},   32'd0);
        check("rst_hrdata", HRDATA,             32'd0);

        // Back-to-back word writes to seed the RAM (write->write)
        wr_t(32'h00, 3'd2, 32'h0000_1111, "seed00");
        wr_t(32'h04, 3'd2, 32'h2222_0004, "seed04");
        wr_t(32'h08, 3'd2, 32'h3333_0008, "seed08");
        wr_t(32'h20, 3'd2, 32'h1234_5678, "seed20");
        wr_t(32'h40, 3'd2, 32'h4040_4040, "seed40");
        wr_t(32'h50, 3'd2, 32'h5050_5050, "seed50");
        wr_t(32'h54, 3'd2, 32'h5454_5454, "seed54");
        idle();

        // Word write, idle, read back
        wr_t(32'h10, 3'd2, 32'hDEAD_BEEF, "t1_wr");
        idle();
        rd_t(32'h10, "t1_rd");

        // Byte write into the top lane
        wr_t(32'h13, 3'd0, 32'h1100_0000, "t2_wr");
        idle();
        rd_t(32'h10, "t2_rd");

        // Halfword write immediately followed by a read of the same word
        wr_t(32'h20, 3'd1, 32'h0000_CAFE, "t3_wr");
        rd_t(32'h20, "t3_fwd");
        // Upper halfword and single byte forwarding
        wr_t(32'h0A, 3'd1, 32'h7777_0000, "t3b_wr");
        rd_t(32'h08, "t3b_fwd");
        wr_t(32'h12, 3'd0, 32'h0099_0000, "t3c_wr");
        rd_t(32'h10, "t3c_fwd");
        // Write then read of a different word: no forwarding
        wr_t(32'h50, 3'd2, 32'hFACE_0050, "t3d_wr");
        rd_t(32'h54, "t3d_nofwd");
        // Read then write: no hazard
        rd_t(32'h50, "t3e_rd");
        wr_t(32'h51, 3'd0, 32'h0000_AB00, "t3e_wr");
        idle();
        rd_t(32'h50, "t3e_rd2");

        // Misaligned word write -> ERROR, no RAM write
        wr_t(32'h22, 3'd2, 32'hFFFF_FFFF, "t4_err");
        idle();
        idle();
        rd_t(32'h20, "t4_rd");

        // Misaligned halfword write -> ERROR
        wr_t(32'h01, 3'd1, 32'hFFFF_FFFF, "t4b_err");
        idle();
        idle();

        // Oversized read -> ERROR, then back-to-back reads
        rd_t(32'h00, "t5_err", 3'd3);
        idle();
        idle();
        rd_t(32'h00, "t5_rd0");
        rd_t(32'h04, "t5_rd4");
        rd_t(32'h08, "t5_rd8");

        // Reset during a write data phase drops the write
        wr_t(32'h40, 3'd2, 32'hA5A5_A5A5, "t6_wr", 1'b1);
        rst_cycle();
        idle();
        rd_t(32'h40, "t6_rd");

        repeat (3) idle();
        check("sb_drain", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
